// File: rtl/uart_pkg.sv
// uart_pkg: register addresses, CON bit positions and the shared UART FSM state type
package uart_pkg;
    localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
    localparam logic [31:0] UART_RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;
    localparam int CON_TX_DONE    = 0;
    localparam int CON_RX_VALID   = 1;
    localparam int CON_TX_BUSY    = 2;
    localparam int CON_RX_OVERRUN = 3;
    localparam int CON_FRAME_ERR  = 4;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
    function automatic logic addr_hit(input logic [31:0] a, input logic [31:0] reg_addr);
        return (a & ~32'h3) == reg_addr;
    endfunction
endpackage

// File: rtl/uart_mmio_if.sv
// uart_mmio_if: MEM-stage peripheral bus carrying strobes, address, store data and load data
interface uart_mmio_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    modport master (output mem_rd, mem_wr, addr, wr_data, input rd_data);
    modport slave  (input mem_rd, mem_wr, addr, wr_data, output rd_data);
endinterface

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing one 16x-oversample tick per wrap
module uart_baud_gen #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int W = $clog2(DIV + 1);
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = cnt_q == LAST;
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART with TXD/RXD/CON registers and a level interrupt
module uart_mmio import uart_pkg::*; #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     reset,
    uart_mmio_if.slave bus,
    input  logic     uart_rx,
    output logic     uart_tx,
    output logic     irq
);
    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
    logic tick, rd_txd, rd_rxd, rd_con, wr_txd, tx_busy, tx_fin, rx_done, rx_ferr, unused_ok;
    uart_state_e tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic [3:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0] tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
    logic [7:0] txd_q, txd_d, rxd_q, rxd_d, rx_sh_q, rx_sh_d;
    logic tx_q, tx_d, rx_meta_q, rx_sync_q;
    logic tx_done_q, tx_done_d, rx_valid_q, rx_valid_d, ovr_q, ovr_d, ferr_q, ferr_d;
    logic [31:0] con;
    uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_baud (.clk(clk), .reset(reset), .tick(tick));
    assign unused_ok = ^bus.wr_data[31:8];
    always_comb begin
        rd_txd  = bus.mem_rd && addr_hit(bus.addr, UART_TXD_ADDR);
        rd_rxd  = bus.mem_rd && addr_hit(bus.addr, UART_RXD_ADDR);
        rd_con  = bus.mem_rd && addr_hit(bus.addr, UART_CON_ADDR);
        wr_txd  = bus.mem_wr && addr_hit(bus.addr, UART_TXD_ADDR);
        tx_busy = tx_st_q != IDLE;
    end
    // Line output is registered from next-state values so uart_tx changes with the state
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_idx_d = tx_idx_q;
        txd_d    = txd_q;
        tx_fin   = 1'b0;
        if (tx_st_q == IDLE) begin
            if (wr_txd) begin
                txd_d    = bus.wr_data[7:0];
                tx_st_d  = START;
                tx_cnt_d = '0;
                tx_idx_d = '0;
            end
        end else if (tick) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            if (tx_cnt_q == LAST_TICK) begin
                tx_idx_d = tx_st_q == DATA ? tx_idx_q + 3'd1 : '0;
                tx_st_d  = tx_st_q == START ? DATA : tx_st_q == STOP ? IDLE : tx_idx_q == 3'd7 ? STOP : DATA;
                tx_fin   = tx_st_q == STOP;
            end
        end
        tx_d = tx_st_d == START ? 1'b0 : tx_st_d == DATA ? txd_d[tx_idx_d] : 1'b1;
    end
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_idx_d = rx_idx_q;
        rx_sh_d  = rx_sh_q;
        rx_done  = 1'b0;
        rx_ferr  = 1'b0;
        if (rx_st_q == IDLE) begin
            if (!rx_sync_q) begin
                rx_st_d  = START;
                rx_cnt_d = '0;
            end
        end else if (tick) begin
            rx_cnt_d = rx_cnt_q + 4'd1;
            if (rx_st_q == START && rx_cnt_q == MID_TICK) begin
                rx_st_d  = rx_sync_q ? IDLE : DATA;
                rx_cnt_d = '0;
                rx_idx_d = '0;
            end else if (rx_st_q == DATA && rx_cnt_q == LAST_TICK) begin
                rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                rx_idx_d = rx_idx_q + 3'd1;
                rx_st_d  = rx_idx_q == 3'd7 ? STOP : DATA;
            end else if (rx_st_q == STOP && rx_cnt_q == LAST_TICK) begin
                rx_st_d = IDLE;
                rx_done = rx_sync_q;
                rx_ferr = !rx_sync_q;
            end
        end
        rxd_d = rx_done ? rx_sh_q : rxd_q;
    end
    always_comb begin
        tx_done_d  = tx_fin | (tx_done_q & ~rd_con);
        rx_valid_d = rx_done | (rx_valid_q & ~rd_rxd);
        ovr_d      = (rx_done & rx_valid_q & ~rd_rxd) | (ovr_q & ~rd_con);
        ferr_d     = rx_ferr | (ferr_q & ~rd_con);
        con = '0;
        con[CON_TX_DONE]    = tx_done_q;
        con[CON_RX_VALID]   = rx_valid_q;
        con[CON_TX_BUSY]    = tx_busy;
        con[CON_RX_OVERRUN] = ovr_q;
        con[CON_FRAME_ERR]  = ferr_q;
        bus.rd_data = rd_txd ? {24'h0, txd_q} : rd_rxd ? {24'h0, rxd_q} : rd_con ? con : '0;
        irq = tx_done_q | rx_valid_q;
        uart_tx = tx_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_st_q <= IDLE;  tx_cnt_q <= '0; tx_idx_q <= '0; txd_q <= '0; tx_q <= 1'b1;
            rx_st_q <= IDLE;  rx_cnt_q <= '0; rx_idx_q <= '0; rxd_q <= '0; rx_sh_q <= '0;
            rx_meta_q <= 1'b1; rx_sync_q <= 1'b1;
            tx_done_q <= 1'b0; rx_valid_q <= 1'b0; ovr_q <= 1'b0; ferr_q <= 1'b0;
        end else begin
            tx_st_q <= tx_st_d; tx_cnt_q <= tx_cnt_d; tx_idx_q <= tx_idx_d; txd_q <= txd_d; tx_q <= tx_d;
            rx_st_q <= rx_st_d; rx_cnt_q <= rx_cnt_d; rx_idx_q <= rx_idx_d; rxd_q <= rxd_d; rx_sh_q <= rx_sh_d;
            rx_meta_q <= uart_rx; rx_sync_q <= rx_meta_q;
            tx_done_q <= tx_done_d; rx_valid_q <= rx_valid_d; ovr_q <= ovr_d; ferr_q <= ferr_d;
        end
    end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped UART controller on the CPU's MEM-stage peripheral bus.
- Consumes the MEM-stage read strobe, write strobe, ALU address and store data.
- Returns read data that the MEM stage muxes into its load-data path for addresses 0x40000018–0x40000023.
- Serialises and deserialises 8N1 frames on uart_tx/uart_rx and flags completion via irq.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line baud rate
OVERSAMPLE, 16, baud ticks per bit (fixed to 16; not user-varied)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
mem_rd  input  1  MEM-stage load strobe
mem_wr  input  1  MEM-stage store strobe
addr  input  32  MEM-stage byte address (ALU result)
wr_data  input  32  store data
rd_data  output  32  load data, combinational from addr; 0 when unmapped or mem_rd=0
uart_rx  input  1  serial input, asynchronous
uart_tx  output  1  serial output, idle high
irq  output  1  level interrupt

Behaviour:
Interface:
- One clock, clk.
- Reset is synchronous and active-high, port reset.

Reset values:
- uart_tx=1, irq=0, rd_data=0.
- All flags, TXD and RXD are 0.
- Both FSMs are IDLE and the divider is 0.

Baud tick:
- DIV = CLK_FREQ/(BAUD*16), integer truncation. Default 325.
- Counter runs 0..DIV-1 and emits a 1-cycle tick at wrap.
- The counter free-runs from reset.

Register map (word addresses; accesses are 32-bit and addr[1:0] is ignored):
- 0x40000018 TXD (RW):
  - Write of wr_data[7:0] when tx idle: latch the byte and start a frame on the next cycle.
  - Write while tx_busy: ignored, TXD unchanged.
  - Read returns {24'b0, TXD}.
- 0x4000001C RXD (RO):
  - Read returns {24'b0, last received byte}.
  - A read clears rx_valid at the clock edge.
- 0x40000020 CON (RO). Writes are ignored. Bit fields:
  - [0] tx_done: sticky.
  - [1] rx_valid.
  - [2] tx_busy.
  - [3] rx_overrun: sticky.
  - [4] frame_err: sticky.
  - [31:5] = 0.
  - A CON read clears bits 0, 3 and 4 at the clock edge.
- irq = tx_done | rx_valid.
- Clear-on-read acts only when mem_rd=1 and the address matches in that cycle.

TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- Each bit lasts 16 ticks.
- START drives 0.
- DATA sends bits 0..7, LSB first, using a 3-bit index.
- STOP drives 1.
- tx_busy=1 from the cycle after the accepted write until STOP's 16th tick; tx_done sets in that same cycle.
- Bit period accuracy is +0/−1 tick, because the divider phase is not reset at start.

RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
- uart_rx passes through a 2-flop synchroniser.
- IDLE: on synchronised low, go to START and zero the tick count.
- START: at tick 8, if line=1 it is a false start (back to IDLE, no flag change); otherwise go to DATA.
- DATA: sample every 16 ticks, at mid-bit, into a shift register, LSB first.
- STOP: sample at mid-bit.
  - Stop sample 1: write RXD and set rx_valid; if rx_valid was already 1 and is not being cleared this cycle, set rx_overrun. Return to IDLE.
  - Stop sample 0: set frame_err, discard the byte (RXD unchanged), return to IDLE.

Simultaneous events:
- RXD read in the same cycle as an RX completion: new byte written, rx_valid stays 1, no overrun.
- CON read in the same cycle as a flag set: the set wins.
- TXD write in the same cycle tx_done sets: tx is not yet idle, so the write is ignored.

Reset mid-frame:
- uart_tx returns to 1 in the next cycle.
- Any partial RX byte is discarded.

Decomposition:
- Package uart_pkg:
  - Address constants UART_TXD_ADDR, UART_RXD_ADDR, UART_CON_ADDR.
  - CON bit-index constants.
  - Shared FSM state enum {IDLE, START, DATA, STOP}.
- Sub-module uart_baud_gen (parameters CLK_FREQ, BAUD; outputs tick) instantiated once.
- TX FSM, RX FSM and the register file stay in uart_mmio.

Test Plan:
Simulation parameters: CLK_FREQ=1600000, BAUD=10000, giving DIV=10 and 160 cycles per bit.
1. Write 0x000000A5 to 0x40000018 -> uart_tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 160±10 cycles. CON reads 0x4 during the frame and 0x1 after, then 0x0 on re-read. irq follows tx_done.
2. Drive RX frame 0x3C -> after the stop mid-bit, CON=0x2 and irq=1. Read RXD -> 0x0000003C. Next CON read -> 0x0 and irq=0.
3. Two RX frames 0x11 then 0x22 with no RXD read -> RXD=0x22, CON=0xA. CON read clears bit 3 -> 0x2.
4. RX frame with stop bit driven 0 -> CON bit4=1, rx_valid=0, RXD unchanged. Separately, a 40-cycle low glitch -> no flag change.
5. Write TXD 0x55 then 0xFF mid-frame -> only the 0x55 frame appears on the line and TXD reads 0x55. Assert reset mid-frame -> uart_tx=1 next cycle and CON=0x0.
6. Read at 0x40000024 and 0x40000014, and any address with mem_rd=0 -> rd_data=0x00000000. Write to CON -> no flag change.
